// File: rtl/reg_filter_pkg.sv
// Shared types and helpers for the strobe-filtering register bridge.
package reg_filter_pkg;

    // The request/response structs and the merge helper are sized here; the top
    // checks at elaboration that its width parameters agree with these.
    localparam int unsigned PkgAddrWidth = 32;
    localparam int unsigned PkgDataWidth = 32;
    localparam int unsigned PkgStrbWidth = PkgDataWidth / 8;

    typedef struct packed {
        logic [PkgAddrWidth-1:0] addr;
        logic                    write;
        logic [PkgDataWidth-1:0] wdata;
        logic [PkgStrbWidth-1:0] wstrb;
        logic                    valid;
    } reg_req_t;

    typedef struct packed {
        logic [PkgDataWidth-1:0] rdata;
        logic                    error;
        logic                    ready;
    } reg_rsp_t;

    typedef enum logic [1:0] {
        StIdle,
        StEack,
        StRd,
        StWr
    } state_e;

    // Byte-wise merge: strobed bytes come from wdata, the rest from old_data.
    function automatic logic [PkgDataWidth-1:0] strb_merge(
        input logic [PkgDataWidth-1:0] wdata,
        input logic [PkgDataWidth-1:0] old_data,
        input logic [PkgStrbWidth-1:0] strb
    );
        logic [PkgDataWidth-1:0] res;
        res = old_data;
        for (int unsigned i = 0; i < PkgStrbWidth; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module reg_sat_counter #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [CntWidth-1:0] cnt_o
);

    logic [CntWidth-1:0] cnt_q;

    // Count up, hold at all-ones, clear on request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_filter_strb_rmw.sv
// Register-interface filter for a strobe-less target: acks empty writes locally
// and turns partial-strobe writes into read-modify-write pairs.
module reg_filter_strb_rmw
    import reg_filter_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter bit          RmwEnable     = 1'b1,
    parameter int unsigned EmptyAckDelay = 0,
    parameter int unsigned CntWidth      = 16,
    parameter type         req_t         = reg_filter_pkg::reg_req_t,
    parameter type         rsp_t         = reg_filter_pkg::reg_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  req_t                in_req_i,
    output rsp_t                in_rsp_o,
    output req_t                out_req_o,
    input  rsp_t                out_rsp_i,
    input  logic                cnt_clr_i,
    output logic [CntWidth-1:0] cnt_empty_o,
    output logic [CntWidth-1:0] cnt_rmw_o,
    output logic                busy_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    if (DataWidth % 8 != 0) begin : gen_err_data_width
        $error("DataWidth must be a multiple of 8");
    end
    if (EmptyAckDelay > 1) begin : gen_err_empty_ack_delay
        $error("EmptyAckDelay must be 0 or 1");
    end
    if (($bits(in_req_i.addr) != AddrWidth) || ($bits(in_req_i.wdata) != DataWidth) ||
        ($bits(in_req_i.wstrb) != StrbWidth) || (DataWidth != PkgDataWidth)) begin : gen_err_types
        $error("req_t/rsp_t field widths do not match AddrWidth/DataWidth");
    end

    state_e               state_q, state_d;
    logic [DataWidth-1:0] merge_q, merge_d;
    logic                 inc_empty;
    logic                 inc_rmw;
    logic                 is_empty_wr;
    logic                 is_partial_wr;

    assign is_empty_wr   = in_req_i.valid && in_req_i.write && (in_req_i.wstrb == '0);
    assign is_partial_wr = in_req_i.valid && in_req_i.write && (in_req_i.wstrb != '0) &&
                           (in_req_i.wstrb != '1);

    // State and merge register; reset mid-sequence drops back to idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

    // Next state, downstream request and upstream response.
    always_comb begin
        state_d   = state_q;
        merge_d   = merge_q;
        out_req_o = in_req_i;
        in_rsp_o  = out_rsp_i;
        inc_empty = 1'b0;
        inc_rmw   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_empty_wr) begin
                    out_req_o.valid = 1'b0;
                    in_rsp_o        = '0;
                    inc_empty       = 1'b1;
                    if (EmptyAckDelay == 0) begin
                        in_rsp_o.ready = 1'b1;
                    end else begin
                        state_d = StEack;
                    end
                end else if (RmwEnable && is_partial_wr) begin
                    out_req_o.valid = 1'b0;
                    in_rsp_o        = '0;
                    inc_rmw         = 1'b1;
                    state_d         = StRd;
                end
            end

            StEack: begin
                out_req_o.valid = 1'b0;
                in_rsp_o        = '0;
                in_rsp_o.ready  = 1'b1;
                state_d         = StIdle;
            end

            StRd: begin
                out_req_o.write = 1'b0;
                out_req_o.valid = 1'b1;
                in_rsp_o        = '0;
                if (out_rsp_i.ready) begin
                    if (out_rsp_i.error) begin
                        // Failed read: report upstream and never issue the write.
                        in_rsp_o.ready = 1'b1;
                        in_rsp_o.error = 1'b1;
                        state_d        = StIdle;
                    end else begin
                        merge_d = out_rsp_i.rdata;
                        state_d = StWr;
                    end
                end
            end

            StWr: begin
                out_req_o.write = 1'b1;
                out_req_o.wstrb = '1;
                out_req_o.wdata = strb_merge(in_req_i.wdata, merge_q, in_req_i.wstrb);
                out_req_o.valid = 1'b1;
                in_rsp_o        = '0;
                if (out_rsp_i.ready) begin
                    in_rsp_o.ready = 1'b1;
                    in_rsp_o.error = out_rsp_i.error;
                    state_d        = StIdle;
                end
            end
        endcase
    end

    reg_sat_counter #(
        .CntWidth(CntWidth)
    ) u_cnt_empty (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (cnt_clr_i),
        .inc_i (inc_empty),
        .cnt_o (cnt_empty_o)
    );

    reg_sat_counter #(
        .CntWidth(CntWidth)
    ) u_cnt_rmw (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (cnt_clr_i),
        .inc_i (inc_rmw),
        .cnt_o (cnt_rmw_o)
    );

    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_reg_filter_strb_rmw.sv
// Directed bench: dut0 acks empty writes immediately, dut1 one cycle later.
module tb_reg_filter_strb_rmw;
    import reg_filter_pkg::*;

    localparam int unsigned CntW = 4;

    logic clk;
    logic rst_n;
    reg_req_t req0, oreq0, req1, oreq1;
    reg_rsp_t rsp0, orsp0, rsp1, orsp1;
    logic clr0, clr1;
    logic [CntW-1:0] ce0, cr0, ce1, cr1;
    logic busy0, busy1;

    int checks;
    int failures;

    // Target model for dut0: zero-wait, strobed writes, optional read error.
    logic [31:0] tgt_data;
    logic        tgt_rd_err;
    logic        tgt_load;
    logic [31:0] tgt_load_val;
    int          tgt_wr_cnt;
    int          v1_cnt;

    reg_filter_strb_rmw #(
        .AddrWidth(32), .DataWidth(32), .RmwEnable(1'b1), .EmptyAckDelay(0), .CntWidth(CntW)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .in_req_i(req0), .in_rsp_o(rsp0), .out_req_o(oreq0),
        .out_rsp_i(orsp0), .cnt_clr_i(clr0), .cnt_empty_o(ce0), .cnt_rmw_o(cr0), .busy_o(busy0)
    );

    reg_filter_strb_rmw #(
        .AddrWidth(32), .DataWidth(32), .RmwEnable(1'b1), .EmptyAckDelay(1), .CntWidth(CntW)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_req_i(req1), .in_rsp_o(rsp1), .out_req_o(oreq1),
        .out_rsp_i(orsp1), .cnt_clr_i(clr1), .cnt_empty_o(ce1), .cnt_rmw_o(cr1), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        orsp0       = '0;
        orsp0.ready = oreq0.valid;
        orsp0.rdata = tgt_data;
        orsp0.error = tgt_rd_err && !oreq0.write;
        orsp1       = '0;
        orsp1.ready = oreq1.valid;
    end

    always @(posedge clk) begin
        if (tgt_load) begin
            tgt_data <= tgt_load_val;
        end else if (oreq0.valid && oreq0.write && orsp0.ready) begin
            for (int i = 0; i < 4; i++) begin
                if (oreq0.wstrb[i]) tgt_data[8*i +: 8] <= oreq0.wdata[8*i +: 8];
            end
            tgt_wr_cnt <= tgt_wr_cnt + 1;
        end
        if (oreq1.valid) v1_cnt <= v1_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_target(input logic [31:0] val);
        tgt_load_val = val;
        tgt_load     = 1'b1;
        tick();
        tgt_load     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (busy0 !== 1'b0 || oreq0.valid !== 1'b0 || ce0 !== 4'd0 || cr0 !== 4'd0) begin
            failures++;
            $display("FAIL reset: busy=%b oval=%b ce=%0d cr=%0d, want 0/0/0/0",
                     busy0, oreq0.valid, ce0, cr0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_empty_delay0();
        req0 = '{addr: 32'h10, write: 1'b1, wdata: 32'h12345678, wstrb: 4'h0, valid: 1'b1};
        #1;
        checks++;
        if (oreq0.valid !== 1'b0 || rsp0.ready !== 1'b1 || rsp0.error !== 1'b0 ||
            rsp0.rdata !== 32'h0) begin
            failures++;
            $display("FAIL empty_d0_ack: oval=%b rdy=%b err=%b rdata=%h, want 0/1/0/0",
                     oreq0.valid, rsp0.ready, rsp0.error, rsp0.rdata);
        end
        tick();
        req0.valid = 1'b0;
        checks++;
        if (ce0 !== 4'd1 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL empty_d0_cnt: ce=%0d busy=%b, want 1/0", ce0, busy0);
        end
    endtask

    task automatic test_empty_delay1();
        req1 = '{addr: 32'h10, write: 1'b1, wdata: 32'h12345678, wstrb: 4'h0, valid: 1'b1};
        #1;
        checks++;
        if (rsp1.ready !== 1'b0 || oreq1.valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_d1_c0: rdy=%b oval=%b, want 0/0", rsp1.ready, oreq1.valid);
        end
        tick();
        checks++;
        if (rsp1.ready !== 1'b1 || rsp1.error !== 1'b0 || oreq1.valid !== 1'b0 ||
            busy1 !== 1'b1) begin
            failures++;
            $display("FAIL empty_d1_c1: rdy=%b err=%b oval=%b busy=%b, want 1/0/0/1",
                     rsp1.ready, rsp1.error, oreq1.valid, busy1);
        end
        tick();
        req1.valid = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || ce1 !== 4'd1 || v1_cnt !== 0) begin
            failures++;
            $display("FAIL empty_d1_end: busy=%b ce=%0d vcnt=%0d, want 0/1/0",
                     busy1, ce1, v1_cnt);
        end
    endtask

    task automatic test_full_write();
        req0 = '{addr: 32'h20, write: 1'b1, wdata: 32'hDEADBEEF, wstrb: 4'hF, valid: 1'b1};
        #1;
        checks++;
        if (oreq0 !== req0 || rsp0.ready !== 1'b1) begin
            failures++;
            $display("FAIL full_pass: oreq=%h rdy=%b, want %h/1", oreq0, rsp0.ready, req0);
        end
        tick();
        req0 = '{addr: 32'h20, write: 1'b0, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
        #1;
        checks++;
        if (tgt_data !== 32'hDEADBEEF || cr0 !== 4'd0 || rsp0.rdata !== 32'hDEADBEEF ||
            oreq0.write !== 1'b0 || oreq0.valid !== 1'b1) begin
            failures++;
            $display("FAIL full_read: tgt=%h cr=%0d rdata=%h ow=%b ov=%b, want deadbeef/0/deadbeef/0/1",
                     tgt_data, cr0, rsp0.rdata, oreq0.write, oreq0.valid);
        end
        tick();
        req0.valid = 1'b0;
    endtask

    task automatic test_rmw();
        load_target(32'h11223344);
        req0 = '{addr: 32'h30, write: 1'b1, wdata: 32'hAABBCCDD, wstrb: 4'h5, valid: 1'b1};
        #1;
        checks++;
        if (oreq0.valid !== 1'b0 || rsp0.ready !== 1'b0) begin
            failures++;
            $display("FAIL rmw_idle: oval=%b rdy=%b, want 0/0", oreq0.valid, rsp0.ready);
        end
        tick();
        checks++;
        if (busy0 !== 1'b1 || oreq0.valid !== 1'b1 || oreq0.write !== 1'b0 ||
            oreq0.addr !== 32'h30 || rsp0.ready !== 1'b0) begin
            failures++;
            $display("FAIL rmw_rd: busy=%b ov=%b ow=%b addr=%h rdy=%b, want 1/1/0/30/0",
                     busy0, oreq0.valid, oreq0.write, oreq0.addr, rsp0.ready);
        end
        tick();
        checks++;
        if (oreq0.valid !== 1'b1 || oreq0.write !== 1'b1 || oreq0.wdata !== 32'h11BB33DD ||
            oreq0.wstrb !== 4'hF || rsp0.ready !== 1'b1 || rsp0.error !== 1'b0) begin
            failures++;
            $display("FAIL rmw_wr: ov=%b ow=%b wd=%h ws=%h rdy=%b err=%b, want 1/1/11bb33dd/f/1/0",
                     oreq0.valid, oreq0.write, oreq0.wdata, oreq0.wstrb, rsp0.ready, rsp0.error);
        end
        tick();
        req0.valid = 1'b0;
        checks++;
        if (tgt_data !== 32'h11BB33DD || cr0 !== 4'd1 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL rmw_end: tgt=%h cr=%0d busy=%b, want 11bb33dd/1/0",
                     tgt_data, cr0, busy0);
        end
    endtask

    task automatic test_rmw_rd_error();
        int wr_before;
        wr_before  = tgt_wr_cnt;
        tgt_rd_err = 1'b1;
        req0 = '{addr: 32'h40, write: 1'b1, wdata: 32'h0000FFFF, wstrb: 4'h3, valid: 1'b1};
        tick();
        checks++;
        if (rsp0.ready !== 1'b1 || rsp0.error !== 1'b1 || oreq0.write !== 1'b0) begin
            failures++;
            $display("FAIL rmw_err_rsp: rdy=%b err=%b ow=%b, want 1/1/0",
                     rsp0.ready, rsp0.error, oreq0.write);
        end
        tick();
        req0.valid = 1'b0;
        tgt_rd_err = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b0 || tgt_wr_cnt !== wr_before || oreq0.valid !== 1'b0 ||
            cr0 !== 4'd2) begin
            failures++;
            $display("FAIL rmw_err_end: busy=%b wrs=%0d ov=%b cr=%0d, want 0/%0d/0/2",
                     busy0, tgt_wr_cnt, oreq0.valid, cr0, wr_before);
        end
    endtask

    task automatic test_counters();
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        checks++;
        if (ce0 !== 4'd0 || cr0 !== 4'd0) begin
            failures++;
            $display("FAIL cnt_clr: ce=%0d cr=%0d, want 0/0", ce0, cr0);
        end
        // Back-to-back empty writes, one accepted per cycle: 2^4 + 3 of them.
        req0 = '{addr: 32'h50, write: 1'b1, wdata: 32'h0, wstrb: 4'h0, valid: 1'b1};
        for (int i = 0; i < 19; i++) tick();
        checks++;
        if (ce0 !== 4'hF) begin
            failures++;
            $display("FAIL cnt_sat: ce=%0d, want 15", ce0);
        end
        clr0 = 1'b1;
        tick();
        clr0       = 1'b0;
        req0.valid = 1'b0;
        checks++;
        if (ce0 !== 4'd0) begin
            failures++;
            $display("FAIL cnt_clr_wins: ce=%0d, want 0", ce0);
        end
    endtask

    task automatic test_reset_in_wr();
        load_target(32'h55667788);
        req0 = '{addr: 32'h60, write: 1'b1, wdata: 32'h000000AA, wstrb: 4'h1, valid: 1'b1};
        tick();
        tick();
        checks++;
        if (oreq0.write !== 1'b1 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL rst_wr_enter: ow=%b busy=%b, want 1/1", oreq0.write, busy0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy0 !== 1'b0 || oreq0.valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_wr_abort: busy=%b ov=%b, want 0/0", busy0, oreq0.valid);
        end
        tick();
        rst_n = 1'b1;
        checks++;
        if (tgt_data !== 32'h55667788 || cr0 !== 4'd0) begin
            failures++;
            $display("FAIL rst_wr_nowrite: tgt=%h cr=%0d, want 55667788/0", tgt_data, cr0);
        end
        tick();
        tick();
        checks++;
        if (rsp0.ready !== 1'b1 || oreq0.wdata !== 32'h556677AA) begin
            failures++;
            $display("FAIL rst_wr_retry_wr: rdy=%b wd=%h, want 1/556677aa",
                     rsp0.ready, oreq0.wdata);
        end
        tick();
        req0.valid = 1'b0;
        checks++;
        if (tgt_data !== 32'h556677AA || busy0 !== 1'b0 || cr0 !== 4'd1) begin
            failures++;
            $display("FAIL rst_wr_retry_end: tgt=%h busy=%b cr=%0d, want 556677aa/0/1",
                     tgt_data, busy0, cr0);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        tgt_data     = 32'h0;
        tgt_rd_err   = 1'b0;
        tgt_load     = 1'b0;
        tgt_load_val = 32'h0;
        tgt_wr_cnt   = 0;
        v1_cnt       = 0;
        req0         = '0;
        req1         = '0;
        clr0         = 1'b0;
        clr1         = 1'b0;
        rst_n        = 1'b0;

        test_reset();
        test_empty_delay0();
        test_empty_delay1();
        test_full_write();
        test_rmw();
        test_rmw_rd_error();
        test_counters();
        test_reset_in_wr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
